fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 18 +
 rtl/fetch_stage_fifo.sv | 65 ++++++
 rtl/fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, FSM encoding and queue entry type for the fetch stage
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          FIFO_DEPTH = 2;
  localparam int          FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bundle between fetch and imem
interface fetch_stage_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_ready, i_imem_rvalid, i_imem_rdata
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_ready, i_imem_rvalid, i_imem_rdata
  );
endinterface

// File: rtl/fetch_stage_fifo.sv
// rtl/fetch_stage_fifo.sv - fetch_fifo: small synchronous FIFO with clear, clear wins over push/pop
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_ok     = wr_en_i && (count_q != CW'(DEPTH)) && !clr_i;
  assign rd_ok     = rd_en_i && !empty_o && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch stage: imem requester, 2-entry instruction queue, decode register
// Optional FETCH_PERF_CNT_EN adds delivered/discarded instruction counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_stallD,
  input  logic               i_flushD,
  input  logic               i_redirect,
  input  logic [31:0]        i_redirect_pc,
  fetch_stage_if.master      imem,
  output logic [31:0]        o_InstrD,
  output logic [31:0]        o_PCD,
  output logic [31:0]        o_PCPlus4D,
  output logic               o_validD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [15:0]        o_drop_cnt
`endif
);

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          rsp_pc_q, rsp_pc_d;
  logic [1:0]           out_q, out_d;
  logic [1:0]           drop_q, drop_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          pcd_q, pcd_d;
  logic                 valid_q, valid_d;
  logic [31:0]          target;
  logic                 req, accept, dropping, discard, fifo_wr, fifo_pop, deliver;
  logic [FIFO_CW-1:0]   fifo_count;
  logic                 fifo_empty;
  fetch_entry_t         fifo_head, fifo_in;

  // Space is reserved for every outstanding response, so a response always finds a slot.
  assign req      = rst_n && ((3'(out_q) + 3'(fifo_count)) < 3'd2);
  assign accept   = req && imem.i_imem_ready;
  assign discard  = imem.i_imem_rvalid && (i_redirect || dropping);
  assign fifo_wr  = imem.i_imem_rvalid && !discard;
  assign deliver  = !i_flushD && !i_stallD && !fifo_empty;
  assign fifo_pop = deliver;
  assign target   = i_redirect_pc & ~32'h3;
  assign fifo_in  = '{instr: imem.i_imem_rdata, pc: rsp_pc_q};

  assign imem.o_imem_req  = req;
  assign imem.o_imem_addr = pc_q;
  assign o_InstrD         = instr_q;
  assign o_PCD            = pcd_q;
  assign o_PCPlus4D       = pcd_q + 32'd4;
  assign o_validD         = valid_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (i_redirect),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_in),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    out_d    = out_q + {1'b0, accept} - {1'b0, imem.i_imem_rvalid};
    pc_d     = pc_q;
    drop_d   = drop_q;
    rsp_pc_d = rsp_pc_q;
    if (i_redirect) begin
      pc_d     = target;
      drop_d   = out_d;
      rsp_pc_d = target;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (imem.i_imem_rvalid && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
      if (fifo_wr) rsp_pc_d = rsp_pc_q + 32'd4;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    valid_d = valid_q;
    if (i_flushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!i_stallD) begin
      if (!fifo_empty) begin
        instr_d = fifo_head.instr;
        pcd_d   = fifo_head.pc;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (i_redirect && (drop_d != 2'd0)) state_d = ST_DRAIN;
      ST_DRAIN: if (drop_d == 2'd0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    dropping = 1'b0;
    case (state_q)
      ST_DRAIN: dropping = 1'b1;
      default:  dropping = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= 2'd0;
      drop_q   <= 2'd0;
      instr_q  <= NOP_INSTR;
      pcd_q    <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
      valid_q  <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      if (deliver) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (discard && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized/directed bench for fetch_stage against a queue-based reference model
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed { logic [31:0] pc; logic stale; } inf_t;
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        stallD, flushD, redir;
  logic [31:0] rpc;
  logic [31:0] instrD, pcD, pcp4D;
  logic        validD;
  logic [31:0] instr2, pc2, pcp42;
  logic        valid2;
  logic        z1;
  logic [31:0] z32;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt, fcnt2;
  logic [15:0] dcnt, dcnt2;
`endif

  always #5 clk = ~clk;

  fetch_stage_if mif ();
  fetch_stage_if mif2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .i_stallD(stallD), .i_flushD(flushD),
    .i_redirect(redir), .i_redirect_pc(rpc), .imem(mif),
    .o_InstrD(instrD), .o_PCD(pcD), .o_PCPlus4D(pcp4D), .o_validD(validD)
`ifdef FETCH_PERF_CNT_EN
    , .o_fetch_cnt(fcnt), .o_drop_cnt(dcnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .i_stallD(z1), .i_flushD(z1),
    .i_redirect(z1), .i_redirect_pc(z32), .imem(mif2),
    .o_InstrD(instr2), .o_PCD(pc2), .o_PCPlus4D(pcp42), .o_validD(valid2)
`ifdef FETCH_PERF_CNT_EN
    , .o_fetch_cnt(fcnt2), .o_drop_cnt(dcnt2)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int first_valid = -1;
  int st_pct, fl_pct, rd_pct, rdy_pct, rv_pct;

  logic [31:0] m_pc, m_instr, m_pcD;
  logic        m_valid;
  logic [31:0] m_fcnt;
  logic [15:0] m_dcnt;
  inf_t        m_inf[$];
  ent_t        m_fifo[$];
  logic [31:0] mem_q[$];
  logic [31:0] a2[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcD = 32'h0; m_valid = 1'b0;
    m_fcnt = 32'h0; m_dcnt = 16'h0;
    m_inf.delete(); m_fifo.delete(); mem_q.delete();
  endtask

  task automatic check_outputs();
    chk("imem_req", {31'h0, mif.o_imem_req}, {31'h0, (m_inf.size() + m_fifo.size()) < 2});
    chk("imem_addr", mif.o_imem_addr, m_pc);
    chk("validD", {31'h0, validD}, {31'h0, m_valid});
    chk("InstrD", instrD, m_instr);
    chk("PCD", pcD, m_pcD);
    chk("PCPlus4D", pcp4D, m_pcD + 32'd4);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fcnt, m_fcnt);
    chk("drop_cnt", {16'h0, dcnt}, {16'h0, m_dcnt});
`endif
  endtask

  task automatic step();
    bit   acc, got;
    inf_t h;
    ent_t e, resp;
    @(negedge clk);
    acc = ((m_inf.size() + m_fifo.size()) < 2) && mif.i_imem_ready;
    if (mif.i_imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (mif.o_imem_req && mif.i_imem_ready) mem_q.push_back(mif.o_imem_addr);
    got = 1'b0;
    resp = '0;
    if (mif.i_imem_rvalid && m_inf.size() > 0) begin
      h = m_inf.pop_front();
      if (redir || h.stale) begin
        if (m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
      end else begin
        got = 1'b1;
        resp.instr = memfn(h.pc);
        resp.pc = h.pc;
      end
    end
    if (flushD) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (!stallD) begin
      if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        m_instr = e.instr; m_pcD = e.pc; m_valid = 1'b1;
        m_fcnt = m_fcnt + 32'd1;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
    if (got) m_fifo.push_back(resp);
    if (acc) m_inf.push_back('{pc: m_pc, stale: redir});
    if (redir) begin
      m_fifo.delete();
      foreach (m_inf[i]) m_inf[i].stale = 1'b1;
      m_pc = rpc & ~32'h3;
    end else if (acc) begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    if (validD === 1'b1 && first_valid < 0) first_valid = cyc;
    mif.i_imem_ready  = ($urandom_range(99) < rdy_pct);
    mif.i_imem_rvalid = (mem_q.size() > 0) && ($urandom_range(99) < rv_pct);
    mif.i_imem_rdata  = (mem_q.size() > 0) ? memfn(mem_q[0]) : $urandom;
    stallD = ($urandom_range(99) < st_pct);
    flushD = ($urandom_range(99) < fl_pct);
    redir  = ($urandom_range(99) < rd_pct);
    rpc    = $urandom;
  endtask

  initial begin
    logic [31:0] hold, got_pc, obs;
    bit a;
    rst_n = 1'b0; rst2_n = 1'b0;
    stallD = 1'b0; flushD = 1'b0; redir = 1'b0; rpc = 32'h0;
    z1 = 1'b0; z32 = 32'h0;
    mif.i_imem_ready = 1'b0; mif.i_imem_rvalid = 1'b1; mif.i_imem_rdata = 32'hDEAD_0001;
    mif2.i_imem_ready = 1'b0; mif2.i_imem_rvalid = 1'b0; mif2.i_imem_rdata = 32'h0;
    st_pct = 0; fl_pct = 0; rd_pct = 0; rdy_pct = 100; rv_pct = 100;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, mif.o_imem_req}, 32'h0);
    chk("rst_addr", mif.o_imem_addr, 32'h0);
    chk("rst_validD", {31'h0, validD}, 32'h0);
    chk("rst_InstrD", instrD, NOP);
    chk("rst_PCD", pcD, 32'h0);
    chk("rst2_addr", mif2.o_imem_addr, 32'hFFFF_FFF8);

    // Second instance: RESET_PC near the top of the address space, 1-cycle memory.
    rst2_n = 1'b1;
    mif2.i_imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = mif2.o_imem_req;
      if (a) a2.push_back(mif2.o_imem_addr);
      @(posedge clk);
      #1;
      mif2.i_imem_rvalid = a;
      mif2.i_imem_rdata = $urandom;
    end
    for (int i = 0; i < 3; i++) begin
      obs = (i < a2.size()) ? a2[i] : 32'hxxxx_xxxx;
      chk($sformatf("wrap_addr%0d", i), obs, (i == 0) ? 32'hFFFF_FFF8 : (i == 1) ? 32'hFFFF_FFFC : 32'h0);
    end

    // Main instance leaves reset; responses offered during reset must have been ignored.
    mif.i_imem_rvalid = 1'b0;
    mif.i_imem_ready = 1'b1;
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) step();
    chk("first_valid_cycle", first_valid, 3);

    // Decode stall: instruction held, queue fills, requests stop.
    hold = m_instr;
    stallD = 1'b1; st_pct = 100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_hold", instrD, hold);
    end
    chk("stall_req_low", {31'h0, mif.o_imem_req}, 32'h0);

    // Build two outstanding requests, then redirect to an unaligned target.
    stallD = 1'b0; st_pct = 0; rv_pct = 0;
    mif.i_imem_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    redir = 1'b1; rpc = 32'h0000_0103; flushD = 1'b1;
    step();
    chk("redir_addr", mif.o_imem_addr, 32'h0000_0100);
    rv_pct = 100;
    got_pc = 32'hxxxx_xxxx;
    for (int i = 0; i < 20; i++) begin
      step();
      if (validD === 1'b1) begin
        got_pc = pcD;
        break;
      end
    end
    chk("redir_first_pcd", got_pc, 32'h0000_0100);

    // Flush and stall together.
    st_pct = 100; stallD = 1'b1;
    for (int i = 0; i < 3; i++) step();
    flushD = 1'b1; fl_pct = 100;
    step();
    chk("flush_stall_validD", {31'h0, validD}, 32'h0);
    chk("flush_stall_InstrD", instrD, NOP);
    st_pct = 0; fl_pct = 0; stallD = 1'b0; flushD = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Random traffic.
    st_pct = 20; fl_pct = 10; rd_pct = 5; rdy_pct = 70; rv_pct = 60;
    for (int i = 0; i < 800; i++) step();

    // Reset while draining stale responses.
    st_pct = 0; fl_pct = 0; rd_pct = 0; rdy_pct = 100; rv_pct = 0;
    stallD = 1'b0; flushD = 1'b0; redir = 1'b0; mif.i_imem_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    redir = 1'b1; rpc = 32'h0000_4000;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, mif.o_imem_req}, 32'h0);
    chk("mid_rst_addr", mif.o_imem_addr, 32'h0);
    chk("mid_rst_validD", {31'h0, validD}, 32'h0);
    chk("mid_rst_InstrD", instrD, NOP);
    chk("mid_rst_PCD", pcD, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_fetch_cnt", fcnt, 32'h0);
    chk("mid_rst_drop_cnt", {16'h0, dcnt}, 32'h0);
`endif
    model_reset();
    mif.i_imem_rvalid = 1'b0;
    mif.i_imem_ready = 1'b1;
    redir = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    st_pct = 15; fl_pct = 5; rd_pct = 8; rdy_pct = 80; rv_pct = 70;
    for (int i = 0; i < 300; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
